// File: rtl/aes_pkg.sv
// aes_pkg: controller state type and round-count helper shared with the round datapath
package aes_pkg;
  typedef enum logic [1:0] {IDLE, KINIT, ROUND, DONE} aes_ctrl_state_t;
  function automatic int aes_nr(int k);
    return k == 256 ? 14 : k == 192 ? 12 : 10;
  endfunction
endpackage

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences one AES encryption (load, key-schedule restart, rounds 0..NR, hold result)
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int K = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       start_ready,
  output logic       load_en,
  output logic       kx_reset,
  output logic [3:0] round,
  output logic       first_round,
  output logic       last_round,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);
  localparam logic [3:0] NR = 4'(aes_nr(K));
  if (K != 128 && K != 192 && K != 256) begin : g_bad_k
    $error("aes_round_ctrl: K must be 128, 192 or 256");
  end
  aes_ctrl_state_t state;
  logic [3:0] rnd;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      rnd   <= '0;
    end else
      case (state)
        IDLE:  if (start) state <= KINIT;
        KINIT: begin
          state <= ROUND;
          rnd   <= '0;
        end
        ROUND: if (rnd >= NR) begin
          state <= DONE;
          rnd   <= '0;
        end else rnd <= rnd + 4'd1;
        DONE:  if (out_ready) state <= IDLE;
        default: begin
          state <= IDLE;
          rnd   <= '0;
        end
      endcase
  // reset outranks start, so no load pulse can leak out of a reset cycle
  assign start_ready = state == IDLE;
  assign load_en     = start_ready & start & ~reset;
  assign kx_reset    = reset | (state == KINIT);
  assign round       = state == ROUND ? rnd : 4'd0;
  assign first_round = (state == ROUND) & (rnd == 4'd0);
  assign last_round  = (state == ROUND) & (rnd == NR);
  assign out_valid   = state == DONE;
  assign busy        = (state == KINIT) | (state == ROUND);
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: vector table plus directed multi-cycle sequences for the AES round sequencer
module tb_aes_round_ctrl;
  logic clk = 0, reset, start, out_ready, s2, s3;
  logic sr, le, kx, fr, lr, ov, bs;
  logic [3:0] rd;
  logic sr2, le2, kx2, fr2, lr2, ov2, bs2;
  logic [3:0] rd2;
  logic sr3, le3, kx3, fr3, lr3, ov3, bs3;
  logic [3:0] rd3;
  int total = 0, bad = 0;
  typedef struct {
    logic        rst, st, ordy;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl[17];
  always #5 clk = ~clk;
  aes_round_ctrl #(.K(128)) dut (
    .clk(clk), .reset(reset), .start(start), .start_ready(sr), .load_en(le), .kx_reset(kx),
    .round(rd), .first_round(fr), .last_round(lr), .out_valid(ov), .out_ready(out_ready), .busy(bs)
  );
  aes_round_ctrl #(.K(192)) dut192 (
    .clk(clk), .reset(reset), .start(s2), .start_ready(sr2), .load_en(le2), .kx_reset(kx2),
    .round(rd2), .first_round(fr2), .last_round(lr2), .out_valid(ov2), .out_ready(1'b1), .busy(bs2)
  );
  aes_round_ctrl #(.K(256)) dut256 (
    .clk(clk), .reset(reset), .start(s3), .start_ready(sr3), .load_en(le3), .kx_reset(kx3),
    .round(rd3), .first_round(fr3), .last_round(lr3), .out_valid(ov3), .out_ready(1'b1), .busy(bs3)
  );
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  // invariants that must hold every cycle in every build
  task automatic tick();
    #1;
    chk("ov_busy", {ov & bs, ov2 & bs2, ov3 & bs3}, 0);
    chk("round_max", {rd > 4'd10, rd2 > 4'd12, rd3 > 4'd14}, 0);
    chk("le_ready", {le & ~sr, le2 & ~sr2, le3 & ~sr3}, 0);
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic vec_t mk(logic rst, st, ordy, srx, lex, kxx, logic [3:0] r, logic f, l, o, b);
    mk.rst = rst; mk.st = st; mk.ordy = ordy;
    mk.exp = {srx, lex, kxx, r, f, l, o, b};
  endfunction
  initial begin
    int n, prev, loads, l2c, l3c, o2c, o3c;
    logic [3:0] r2, r3;
    tbl[0] = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    tbl[2] = mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[3] = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i <= 10; i++) tbl[4+i] = mk(0, 0, 1, 0, 0, 0, 4'(i), i == 0, i == 10, 0, 1);
    tbl[15] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[16] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    reset = 1; start = 0; out_ready = 0; s2 = 0; s3 = 0;
    @(negedge clk); @(posedge clk); @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      reset = tbl[i].rst; start = tbl[i].st; out_ready = tbl[i].ordy;
      #1 chk($sformatf("vec%0d", i), {21'd0, sr, le, kx, rd, fr, lr, ov, bs}, {21'd0, tbl[i].exp});
      tick();
    end
    start = 0;
    s2 = 1; s3 = 1;
    #1 chk("t3_load", {le2, le3}, 2'b11);
    tick();
    s2 = 0; s3 = 0; l2c = -1; l3c = -1; o2c = -1; o3c = -1; r2 = 0; r3 = 0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (lr2 && l2c < 0) begin l2c = c; r2 = rd2; end
      if (lr3 && l3c < 0) begin l3c = c; r3 = rd3; end
      if (ov2 && o2c < 0) o2c = c;
      if (ov3 && o3c < 0) o3c = c;
      tick();
    end
    chk("t3_192_last_cyc", l2c, 14);
    chk("t3_192_last_rnd", r2, 12);
    chk("t3_192_valid_cyc", o2c, 15);
    chk("t3_256_last_cyc", l3c, 16);
    chk("t3_256_last_rnd", r3, 14);
    chk("t3_256_valid_cyc", o3c, 17);
    start = 1; out_ready = 0;
    #1 chk("t4_load", le, 1);
    tick();
    start = 0;
    for (int i = 0; i < 20 && !ov; i++) tick();
    chk("t4_reach_done", ov, 1);
    for (int i = 0; i < 5; i++) begin
      start = i % 2 == 0;
      #1 chk("t4_hold_valid", ov, 1);
      chk("t4_no_load", le, 0);
      tick();
    end
    start = 0; out_ready = 1;
    #1 chk("t4_valid_last", ov, 1);
    tick();
    chk("t4_idle", sr, 1);
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 10 && !(bs && rd == 4'd4); i++) tick();
    chk("t5_round4", rd, 4);
    reset = 1;
    #1 chk("t5_kx_reset", kx, 1);
    tick();
    reset = 0;
    #1 chk("t5_after_reset", {sr, rd, bs, ov}, {1'b1, 4'd0, 1'b0, 1'b0});
    start = 1;
    tick();
    start = 0; n = 1;
    while (!ov && n < 30) begin tick(); n++; end
    chk("t5_latency", n, 13);
    tick();
    start = 1; out_ready = 1; prev = -1; loads = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (le) begin
        chk("t6_le_ready", sr, 1);
        if (prev >= 0) chk("t6_gap", c - prev, 14);
        prev = c;
        loads++;
      end
      tick();
    end
    chk("t6_loads", loads, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
